ball_renderer: RTL

Pixel-generation stage directly downstream of the VGA timing generator. Consumes the column/row counters, the visible-area flag and the sync signals, and produces registered 6-bit RGB plus delayed syncs for the DAC pins. Draws a square ball on a solid background. The ball bounces off the screen edges, moves once per frame during vertical blanking, and a pause button freezes it.

---
 rtl/vga_pkg.sv | 57 +++++
 rtl/btn_sync_edge.sv | 34 +++
 rtl/ball_renderer.sv | 117 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, pixel/colour types and the per-axis bounce helper
// for the pixel-generation stage.
package vga_pkg;

    localparam int unsigned H_VIS   = 640;
    localparam int unsigned V_VIS   = 480;
    localparam int unsigned H_TOTAL = 800;
    localparam int unsigned V_TOTAL = 525;

    localparam int unsigned CNT_W = 10;  // timing-generator counter width
    localparam int unsigned POS_W = 11;  // position/compare arithmetic width
    localparam int unsigned RGB_W = 6;
    localparam int unsigned BC_W  = 8;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [POS_W-1:0] pos_t;

    localparam rgb_t BLACK      = 6'b000000;
    localparam rgb_t BG_COLOR   = 6'b000001;
    localparam rgb_t BALL_COLOR = 6'b111100;

    typedef enum logic {RUN, PAUSED} ball_state_t;

    // Next position/direction of one axis; dir_pos=1 means moving towards lim.
    typedef struct packed {
        pos_t pos;
        logic dir_pos;
        logic flip;
    } axis_t;

    function automatic axis_t axis_step(input pos_t pos, input logic dir_pos,
                                        input pos_t lim, input pos_t step);
        axis_t r;
        r.pos     = pos;
        r.dir_pos = dir_pos;
        r.flip    = 1'b0;
        if (dir_pos) begin
            if (pos + step >= lim) begin
                r.pos     = lim;
                r.dir_pos = 1'b0;
                r.flip    = 1'b1;
            end else begin
                r.pos = pos + step;
            end
        end else begin
            if (pos <= step) begin
                r.pos     = '0;
                r.dir_pos = 1'b1;
                r.flip    = 1'b1;
            end else begin
                r.pos = pos - step;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for a raw asynchronous button plus rising-edge
// detector.
//   clk, rst_n : clock, async active-low reset
//   btn        : raw button, active high
//   pulse_c    : one-cycle pulse on each synchronised rising edge
//                (combinational from the flops, valid the cycle after the
//                second synchroniser stage sees the rise)
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse_c
);

    logic sync1;
    logic sync2;
    logic sync2_d;

    // Metastability chain and one-cycle history for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            sync2_d <= 1'b0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            sync2_d <= sync2;
        end
    end

    assign pulse_c = sync2 & ~sync2_d;

endmodule

// File: rtl/ball_renderer.sv
// Pixel stage behind the VGA timing generator: draws a bouncing square ball
// on a solid background, one-cycle registered RGB and delayed syncs.
//   clk, rst_n           : pixel clock, async active-low reset
//   curr_col, curr_row   : timing-generator counters
//   valid                : inside 640x480 visible area
//   hsync_in, vsync_in   : syncs from the timing generator (active low)
//   pause_btn            : raw pause button, each press toggles RUN/PAUSED
//   rgb_out              : registered pixel colour
//   hsync_out, vsync_out : syncs delayed one cycle to match rgb_out
//   bounce_count         : saturating count of frames with a bounce
module ball_renderer
    import vga_pkg::*;
#(
    parameter int unsigned BALL_SIZE = 16,
    parameter int unsigned STEP      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] curr_col,
    input  logic [CNT_W-1:0] curr_row,
    input  logic             valid,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             pause_btn,
    output rgb_t             rgb_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic [BC_W-1:0]  bounce_count
);

    localparam pos_t LIM_X   = POS_W'(H_VIS - BALL_SIZE);
    localparam pos_t LIM_Y   = POS_W'(V_VIS - BALL_SIZE);
    localparam pos_t X_INIT  = POS_W'((H_VIS - BALL_SIZE) / 2);
    localparam pos_t Y_INIT  = POS_W'((V_VIS - BALL_SIZE) / 2);
    localparam pos_t SIZE_W  = POS_W'(BALL_SIZE);
    localparam pos_t STEP_W  = POS_W'(STEP);
    localparam pos_t H_VIS_W = POS_W'(H_VIS);
    localparam pos_t V_VIS_W = POS_W'(V_VIS);

    pos_t        ball_x;
    pos_t        ball_y;
    logic        dir_x;
    logic        dir_y;
    ball_state_t state;

    logic  pause_pulse_c;
    pos_t  col_c;
    pos_t  row_c;
    logic  visible_c;
    logic  in_ball_c;
    logic  frame_tick_c;
    rgb_t  pix_c;
    axis_t ax_c;
    axis_t ay_c;

    btn_sync_edge u_pause (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (pause_btn),
        .pulse_c (pause_pulse_c)
    );

    // Pixel colour and next motion step, all in 11-bit arithmetic
    always_comb begin
        col_c        = POS_W'(curr_col);
        row_c        = POS_W'(curr_row);
        visible_c    = valid && (col_c < H_VIS_W) && (row_c < V_VIS_W);
        in_ball_c    = (col_c >= ball_x) && (col_c < ball_x + SIZE_W) &&
                       (row_c >= ball_y) && (row_c < ball_y + SIZE_W);
        frame_tick_c = (curr_row == CNT_W'(V_VIS)) && (curr_col == '0);
        pix_c        = BLACK;
        if (visible_c) begin
            pix_c = in_ball_c ? BALL_COLOR : BG_COLOR;
        end
        ax_c = axis_step(ball_x, dir_x, LIM_X, STEP_W);
        ay_c = axis_step(ball_y, dir_y, LIM_Y, STEP_W);
    end

    // Output pipeline: colour and syncs from the same input cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_out   <= BLACK;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            rgb_out   <= pix_c;
            hsync_out <= hsync_in;
            vsync_out <= vsync_in;
        end
    end

    // Run/pause FSM and ball motion; motion sees the pre-toggle state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            ball_x       <= X_INIT;
            ball_y       <= Y_INIT;
            dir_x        <= 1'b1;
            dir_y        <= 1'b1;
            bounce_count <= '0;
        end else begin
            if (frame_tick_c && (state == RUN)) begin
                ball_x <= ax_c.pos;
                dir_x  <= ax_c.dir_pos;
                ball_y <= ay_c.pos;
                dir_y  <= ay_c.dir_pos;
                if ((ax_c.flip || ay_c.flip) && (bounce_count != '1)) begin
                    bounce_count <= bounce_count + BC_W'(1);
                end
            end
            if (pause_pulse_c) begin
                state <= (state == RUN) ? PAUSED : RUN;
            end
        end
    end

endmodule
